// File: rtl/sprite_linebuf_dual_if.sv
// Draw-command channel into the sprite line buffer.
// The sprite engine drives the command fields and cmd_valid.
// The line buffer returns cmd_ready.
interface sprite_linebuf_dual_if #(
    parameter int POS_W   = 10,
    parameter int BPP     = 4,
    parameter int COLOR_W = 7,
    parameter int TILE_W  = 16
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [TILE_W*BPP-1:0]   cmd_pixels;
    logic                    cmd_flip;
    logic [COLOR_W-1:0]      cmd_color;
    logic                    cmd_prio;
    logic [POS_W-1:0]        cmd_pos;

    modport master (
        output cmd_valid, cmd_pixels, cmd_flip, cmd_color, cmd_prio, cmd_pos,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_pixels, cmd_flip, cmd_color, cmd_prio, cmd_pos,
        output cmd_ready
    );
endinterface

// File: rtl/sprite_linebuf_dual.sv
// Double-buffered sprite line buffer.
// One buffer scans out to the mixer, reading and clearing one pixel per ce_pix.
// The other buffer is drawn by the sprite engine, two pixels per clock, split
// into an even-x bank and an odd-x bank.
// Optional macro LINEBUF_CLIP_EN: suppresses pixels whose unwrapped x is at or
// beyond LINE_LEN. Without it, x wraps modulo 2^POS_W.
//
// state     | meaning
// ST_INIT   | zeroing every word of both buffers, one address per clock
// ST_IDLE   | waiting for a draw command
// ST_DRAW   | writing TILE_W/2 beats of the active command
module sprite_linebuf_dual #(
    parameter int POS_W     = 10,
    parameter int BPP       = 4,
    parameter int COLOR_W   = 7,
    parameter int TILE_W    = 16,
    parameter int TRANS_PEN = 0,
    parameter int LINE_LEN  = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce_pix,
    input  logic                     scan_toggle,
    input  logic [POS_W-1:0]         scan_pos,
    output logic [COLOR_W+BPP:0]     scan_out,
    sprite_linebuf_dual_if.slave     cmd,
    output logic                     idle,
    output logic                     overrun
);
    localparam int PW     = 1 + COLOR_W + BPP;
    localparam int DEPTH  = 2 ** (POS_W - 1);
    localparam int BEAT_W = (TILE_W > 2) ? $clog2(TILE_W / 2) : 1;
    localparam int PIX_W  = TILE_W * BPP;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(TILE_W / 2 - 1);
    localparam logic [POS_W-2:0]  INIT_LAST = (POS_W - 1)'(DEPTH - 1);
    localparam logic [BPP-1:0]    TRANS     = BPP'(TRANS_PEN);
    localparam logic [POS_W:0]    LINE_LIM  = (POS_W + 1)'(LINE_LEN);
`ifdef LINEBUF_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_DRAW} state_t;

    state_t               state, state_nxt;
    logic [POS_W-2:0]     init_cnt;
    logic [BEAT_W-1:0]    beat;

    // Active command. act_buf holds the index of the buffer being drawn.
    logic [PIX_W-1:0]     act_pixels;
    logic                 act_flip;
    logic [COLOR_W-1:0]   act_color;
    logic                 act_prio;
    logic [POS_W-1:0]     act_pos;
    logic                 act_buf;

    // Skid slot for the command that follows the active one.
    logic                 slot_full;
    logic [PIX_W-1:0]     slot_pixels;
    logic                 slot_flip;
    logic [COLOR_W-1:0]   slot_color;
    logic                 slot_prio;
    logic [POS_W-1:0]     slot_pos;

    logic accept, swap, last_beat;
    logic load_act, load_from_slot, slot_fill, slot_clr;
    logic beat_clr, beat_inc, draw_en, overrun_nxt;

    logic [BPP-1:0]       pix_pen [2];
    logic [POS_W:0]       pix_x   [2];
    logic [1:0]           pix_we;

    logic                 mem_we    [2][2];
    logic [POS_W-2:0]     mem_addr  [2][2];
    logic [PW-1:0]        mem_wdata [2][2];
    logic [PW-1:0]        mem       [2][2][DEPTH];

    logic                 scan_buf;
    logic [POS_W-2:0]     scan_addr;
    logic [PW-1:0]        rd_even, rd_odd;
    logic                 rd_sel;

    assign cmd.cmd_ready = ~slot_full & (state != ST_INIT);
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    // Scan_toggle = 1 scans buffer 0, so the drawn buffer index equals scan_toggle.
    assign scan_buf      = ~scan_toggle;
    assign scan_addr     = scan_pos[POS_W-1:1];
    assign swap          = (state == ST_DRAW) && (scan_toggle != act_buf);
    assign last_beat     = (beat == LAST_BEAT);
    assign idle          = (state == ST_IDLE) & ~slot_full;

    // State register plus the init sweep counter, beat counter and overrun pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            beat     <= '0;
            overrun  <= 1'b0;
        end else begin
            state   <= state_nxt;
            overrun <= overrun_nxt;
            if (state == ST_INIT)
                init_cnt <= init_cnt + 1'b1;
            if (beat_clr)
                beat <= '0;
            else if (beat_inc)
                beat <= beat + 1'b1;
        end
    end

    // Next state and control strobes. A swap kills the remaining beats and the slot.
    always_comb begin
        state_nxt      = state;
        load_act       = 1'b0;
        load_from_slot = 1'b0;
        slot_fill      = 1'b0;
        slot_clr       = 1'b0;
        beat_clr       = 1'b0;
        beat_inc       = 1'b0;
        draw_en        = 1'b0;
        overrun_nxt    = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_cnt == INIT_LAST)
                    state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) begin
                    load_act  = 1'b1;
                    beat_clr  = 1'b1;
                    state_nxt = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (swap) begin
                    overrun_nxt = 1'b1;
                    slot_clr    = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    draw_en = 1'b1;
                    if (last_beat) begin
                        beat_clr = 1'b1;
                        if (slot_full) begin
                            load_act       = 1'b1;
                            load_from_slot = 1'b1;
                            slot_clr       = 1'b1;
                        end else if (accept) begin
                            load_act = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        beat_inc = 1'b1;
                        if (accept)
                            slot_fill = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Active-command and skid-slot registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_pixels  <= '0;
            act_flip    <= 1'b0;
            act_color   <= '0;
            act_prio    <= 1'b0;
            act_pos     <= '0;
            act_buf     <= 1'b0;
            slot_full   <= 1'b0;
            slot_pixels <= '0;
            slot_flip   <= 1'b0;
            slot_color  <= '0;
            slot_prio   <= 1'b0;
            slot_pos    <= '0;
        end else begin
            if (load_act) begin
                act_buf <= scan_toggle;
                if (load_from_slot) begin
                    act_pixels <= slot_pixels;
                    act_flip   <= slot_flip;
                    act_color  <= slot_color;
                    act_prio   <= slot_prio;
                    act_pos    <= slot_pos;
                end else begin
                    act_pixels <= cmd.cmd_pixels;
                    act_flip   <= cmd.cmd_flip;
                    act_color  <= cmd.cmd_color;
                    act_prio   <= cmd.cmd_prio;
                    act_pos    <= cmd.cmd_pos;
                end
            end
            if (slot_clr) begin
                slot_full <= 1'b0;
            end else if (slot_fill) begin
                slot_full   <= 1'b1;
                slot_pixels <= cmd.cmd_pixels;
                slot_flip   <= cmd.cmd_flip;
                slot_color  <= cmd.cmd_color;
                slot_prio   <= cmd.cmd_prio;
                slot_pos    <= cmd.cmd_pos;
            end
        end
    end

    // Pens and x positions of the two pixels in the current beat. x keeps one extra bit for clipping.
    always_comb begin
        int pidx;
        pix_we = 2'b00;
        for (int j = 0; j < 2; j++) begin
            pidx = 2 * int'(beat) + j;
            if (act_flip)
                pidx = TILE_W - 1 - pidx;
            pix_pen[j] = act_pixels[pidx*BPP +: BPP];
            pix_x[j]   = {1'b0, act_pos} + (POS_W + 1)'(2 * int'(beat) + j);
            pix_we[j]  = draw_en && (pix_pen[j] != TRANS) &&
                         (!CLIP_EN || (pix_x[j] < LINE_LIM));
        end
    end

    // Write port per buffer/bank. Init sweep first, then draw, then clear-behind-scan.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 2; k++) begin
                mem_we[b][k]    = 1'b0;
                mem_addr[b][k]  = '0;
                mem_wdata[b][k] = '0;
                if (state == ST_INIT) begin
                    mem_we[b][k]   = 1'b1;
                    mem_addr[b][k] = init_cnt;
                end else begin
                    for (int j = 0; j < 2; j++) begin
                        if (pix_we[j] && (act_buf == 1'(b)) && (pix_x[j][0] == 1'(k))) begin
                            mem_we[b][k]    = 1'b1;
                            mem_addr[b][k]  = pix_x[j][POS_W-1:1];
                            mem_wdata[b][k] = {act_prio, act_color, pix_pen[j]};
                        end
                    end
                    if (!mem_we[b][k] && ce_pix && (scan_buf == 1'(b)) && (scan_pos[0] == 1'(k))) begin
                        mem_we[b][k]   = 1'b1;
                        mem_addr[b][k] = scan_addr;
                    end
                end
            end
        end
    end

    // Line storage: two buffers, each with an even-x and an odd-x bank.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < 2; k++)
                if (mem_we[b][k])
                    mem[b][k][mem_addr[b][k]] <= mem_wdata[b][k];
    end

    // Scan read. The old data is returned even when the same location is cleared in that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_even <= '0;
            rd_odd  <= '0;
            rd_sel  <= 1'b0;
        end else begin
            rd_even <= mem[scan_buf][0][scan_addr];
            rd_odd  <= mem[scan_buf][1][scan_addr];
            rd_sel  <= scan_pos[0];
        end
    end

    assign scan_out = rd_sel ? rd_odd : rd_even;
endmodule

// File: tb/tb_sprite_linebuf_dual.sv
// Directed bench for sprite_linebuf_dual with hand-computed expected pixels.
module tb_sprite_linebuf_dual;
    localparam int POS_W   = 10;
    localparam int BPP     = 4;
    localparam int COLOR_W = 7;
    localparam int TILE_W  = 16;
    localparam int PW      = 1 + COLOR_W + BPP;

    logic              clk = 1'b0;
    logic              reset;
    logic              ce_pix;
    logic              scan_toggle;
    logic [POS_W-1:0]  scan_pos;
    logic [PW-1:0]     scan_out;
    logic              idle;
    logic              overrun;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sprite_linebuf_dual_if #(.POS_W(POS_W), .BPP(BPP), .COLOR_W(COLOR_W), .TILE_W(TILE_W)) cmd_if ();

    sprite_linebuf_dual #(
        .POS_W(POS_W), .BPP(BPP), .COLOR_W(COLOR_W), .TILE_W(TILE_W),
        .TRANS_PEN(0), .LINE_LEN(512)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ce_pix      (ce_pix),
        .scan_toggle (scan_toggle),
        .scan_pos    (scan_pos),
        .scan_out    (scan_out),
        .cmd         (cmd_if),
        .idle        (idle),
        .overrun     (overrun)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] px(input logic prio, input logic [COLOR_W-1:0] col, input int pen);
        logic [BPP-1:0] p;
        p = BPP'(pen);
        return (p == '0) ? '0 : {prio, col, p};
    endfunction

    task automatic scan_px(input int pos, input logic ce, output logic [PW-1:0] val);
        scan_pos = POS_W'(pos);
        ce_pix   = ce;
        @(negedge clk);
        val    = scan_out;
        ce_pix = 1'b0;
    endtask

    task automatic set_cmd(input logic [63:0] pix, input logic flip, input logic [COLOR_W-1:0] col,
                           input logic prio, input int pos);
        cmd_if.cmd_pixels = pix;
        cmd_if.cmd_flip   = flip;
        cmd_if.cmd_color  = col;
        cmd_if.cmd_prio   = prio;
        cmd_if.cmd_pos    = POS_W'(pos);
    endtask

    task automatic send_cmd(input logic [63:0] pix, input logic flip, input logic [COLOR_W-1:0] col,
                            input logic prio, input int pos);
        int t;
        t = 0;
        set_cmd(pix, flip, col, prio, pos);
        cmd_if.cmd_valid = 1'b1;
        while (!cmd_if.cmd_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_if.cmd_ready)
            check_val("cmd_accept_timeout", 32'(cmd_if.cmd_ready), 32'd1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!idle && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!cmd_if.cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nz, cnt, p, j;
        logic [PW-1:0] v;
        logic [PW-1:0] exp;

        reset       = 1'b1;
        ce_pix      = 1'b0;
        scan_toggle = 1'b0;
        scan_pos    = '0;
        cmd_if.cmd_valid = 1'b0;
        set_cmd(64'h0, 1'b0, 7'h0, 1'b0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset values and init sweep length
        check_val("rst_ready",   32'(cmd_if.cmd_ready), 32'd0);
        check_val("rst_idle",    32'(idle),             32'd0);
        check_val("rst_overrun", 32'(overrun),          32'd0);
        check_val("rst_scan",    32'(scan_out),         32'd0);
        wait_ready(n);
        check_val("init_len", 32'(n), 32'd512);
        check_val("init_idle", 32'(idle), 32'd1);
        for (int t = 0; t < 2; t++) begin
            scan_toggle = 1'(t);
            nz = 0;
            for (int q = 0; q < 1024; q++) begin
                scan_px(q, 1'b0, v);
                if (v != '0) nz++;
            end
            check_val($sformatf("init_zero_t%0d", t), 32'(nz), 32'd0);
        end

        // aligned draw at 100, pens 1..15,0
        scan_toggle = 1'b0;
        send_cmd(64'h0FED_CBA9_8765_4321, 1'b0, 7'h12, 1'b1, 100);
        wait_idle(n);
        check_val("draw_lat", 32'(n), 32'd8);
        scan_toggle = 1'b1;
        for (int i = 0; i < 16; i++) begin
            scan_px(100 + i, 1'b1, v);
            exp = px(1'b1, 7'h12, (i < 15) ? i + 1 : 0);
            check_val($sformatf("aligned_x%0d", 100 + i), 32'(v), 32'(exp));
        end
        nz = 0;
        for (int i = 0; i < 16; i++) begin
            scan_px(100 + i, 1'b1, v);
            if (v != '0) nz++;
        end
        check_val("clear_behind", 32'(nz), 32'd0);

        // unaligned flipped draw at 101, pens 0..15
        send_cmd(64'hFEDC_BA98_7654_3210, 1'b1, 7'h05, 1'b0, 101);
        wait_idle(n);
        check_val("unal_lat", 32'(n), 32'd8);
        scan_toggle = 1'b0;
        for (p = 100; p < 118; p++) begin
            j = p - 101;
            scan_px(p, 1'b1, v);
            exp = (j >= 0 && j < 16) ? px(1'b0, 7'h05, 15 - j) : '0;
            check_val($sformatf("unal_x%0d", p), 32'(v), 32'(exp));
        end

        // back-to-back commands through the skid slot
        set_cmd(64'h2222_2222_2222_2222, 1'b0, 7'h21, 1'b0, 200);
        cmd_if.cmd_valid = 1'b1;
        @(negedge clk);
        set_cmd(64'h3333_3333_3333_3333, 1'b0, 7'h33, 1'b0, 216);
        @(negedge clk);
        check_val("b2b_slot_ready", 32'(cmd_if.cmd_ready), 32'd0);
        set_cmd(64'h7777_7777_7777_7777, 1'b0, 7'h77, 1'b0, 600);
        n = 0;
        while (!cmd_if.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmd_if.cmd_valid = 1'b0;
        check_val("slot_drain", 32'(n), 32'd7);
        wait_idle(n);
        check_val("b2b_idle", 32'(n), 32'd8);
        scan_toggle = 1'b1;
        for (p = 200; p < 232; p++) begin
            scan_px(p, 1'b1, v);
            exp = (p < 216) ? px(1'b0, 7'h21, 2) : px(1'b0, 7'h33, 3);
            check_val($sformatf("b2b_x%0d", p), 32'(v), 32'(exp));
        end
        nz = 0;
        for (p = 600; p < 616; p++) begin
            scan_px(p, 1'b0, v);
            if (v != '0) nz++;
        end
        check_val("b2b_third_absent", 32'(nz), 32'd0);

        // swap at beat 3
        send_cmd(64'h4444_4444_4444_4444, 1'b0, 7'h0A, 1'b1, 300);
        repeat (3) @(negedge clk);
        scan_toggle = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (overrun) cnt++;
        end
        check_val("overrun_pulse", 32'(cnt), 32'd1);
        check_val("swap_idle", 32'(idle), 32'd1);
        for (p = 300; p < 316; p++) begin
            scan_px(p, 1'b1, v);
            exp = (p < 306) ? px(1'b1, 7'h0A, 4) : '0;
            check_val($sformatf("swap_x%0d", p), 32'(v), 32'(exp));
        end

        // wrap or clip at 1020
        send_cmd(64'h5555_5555_5555_5555, 1'b0, 7'h11, 1'b0, 1020);
        wait_idle(n);
        scan_toggle = 1'b1;
        for (int q = 0; q < 24; q++) begin
            p = (1016 + q) % 1024;
            scan_px(p, 1'b1, v);
`ifdef LINEBUF_CLIP_EN
            exp = '0;
`else
            exp = (p >= 1020 || p < 12) ? px(1'b0, 7'h11, 5) : '0;
`endif
            check_val($sformatf("wrap_x%0d", p), 32'(v), 32'(exp));
        end

        // reset in the middle of a draw restarts the init sweep
        send_cmd(64'h6666_6666_6666_6666, 1'b0, 7'h01, 1'b1, 400);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_mid_ready", 32'(cmd_if.cmd_ready), 32'd0);
        reset = 1'b0;
        wait_ready(n);
        check_val("reinit_len", 32'(n), 32'd512);
        scan_toggle = 1'b0;
        nz = 0;
        for (p = 400; p < 416; p++) begin
            scan_px(p, 1'b0, v);
            if (v != '0) nz++;
        end
        check_val("rst_clear", 32'(nz), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
